instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage of the 16-bit MIPS datapath; sits directly upstream of decode/register-file/ALU.
- Owns the program counter and drives a synchronous instruction memory (1-cycle read latency).
- Buffers up to two fetched instructions and hands them to decode over a valid/ready handshake.
- Accepts branch/jump redirects from downstream and raises done when the PC runs past the loaded program.

Parameters:
- ADDR_W, 16, PC and instruction-memory word-address width.
- INSTR_W, 32, instruction width; opcode at [31:26].
- INSTR_COUNT, 16, number of valid instruction words; PC == INSTR_COUNT means end of program.
- RESET_PC, 0, PC loaded at reset.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- imem_en  out  1  read request this cycle.
- imem_addr  out  ADDR_W  word address of the request.
- imem_data  in  INSTR_W  read data, valid the cycle after imem_en.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode accepts this cycle.
- out_instr  out  INSTR_W  instruction word.
- out_pc  out  ADDR_W  address of out_instr.
- out_next_pc  out  ADDR_W  out_pc+1 (wraps mod 2^ADDR_W).
- redirect_valid  in  1  taken branch/jump from downstream.
- redirect_pc  in  ADDR_W  redirect target.
- done  out  1  program exhausted, fetch halted, buffer empty.

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, buffer empty, no in-flight read, state=FETCH. Outputs at reset: imem_en=0, imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0, out_next_pc=0, done=0.
- States:
  - FETCH: issuing reads.
  - HALTED: pc == INSTR_COUNT, no issue.
- Transitions:
  - FETCH->HALTED when an issue advances pc to INSTR_COUNT.
  - HALTED->FETCH on redirect with target < INSTR_COUNT.
  - Any state->HALTED on redirect with target >= INSTR_COUNT.
- Issue rule: imem_en=1 iff state==FETCH, !redirect_valid, and (count + inflight - pop) < 2, where pop = out_valid & out_ready. On issue: imem_addr=pc and pc<=pc+1.
- Latency: address issued in cycle N; data captured into the buffer at the end of N+1; out_valid in N+2.
- Throughput: 1 instruction/cycle with out_ready held high.
- Buffer: 2-entry FIFO of {instr, pc}.
  - Never overflows; the issue rule guarantees space.
  - Pop and push in the same cycle are allowed.
  - out_* reflect the head entry.
- Backpressure: out_valid, out_instr and out_pc stay stable while out_valid & !out_ready.
- Redirect (cycle N):
  - out_valid is forced 0 combinationally that cycle, so no transfer occurs.
  - Buffer is flushed.
  - An in-flight response returning in N+1 is discarded.
  - pc <= redirect_pc.
  - First issue of the target in N+1; out_valid for the target in N+3.
- Redirect has priority over issue and push in the same cycle.
- done = (state==HALTED) & (count==0) & !inflight; registered, 0 at reset.
- done drops the cycle after a redirect to a valid target.
- PC arithmetic is modulo 2^ADDR_W. INSTR_COUNT == 2^ADDR_W never halts on its own.
- Reset mid-operation: all state returns to reset values immediately; any pending memory response is ignored, because the in-flight flag is cleared.

Decomposition:
- Shared package mips16_pkg:
  - INSTR_W and ADDR_W defaults;
  - fetch state enum (FETCH, HALTED);
  - opcode field slice constants (OPC_HI=31, OPC_LO=26) for reuse by decode.
- Sub-module fetch_skid_buffer: 2-entry FIFO carrying {instr, pc}, with push, pop, flush and count outputs.

Test Plan:
- Reset, out_ready=1, memory word k = k+0x100: out_valid first high in cycle 2. Then pc 0,1,2,... with instr 0x100,0x101,... on consecutive cycles. out_next_pc = pc+1.
- out_ready low for 5 cycles after pc=3 is shown: out_pc holds 3. At most two reads are outstanding or buffered. On release, pcs 3,4,5 arrive back-to-back with no gap or duplicate.
- redirect_valid with redirect_pc=9 while pc=4 is at the head: out_valid=0 that cycle and the next. Next delivered pc is 9, three cycles later. pcs 4–6 are never delivered.
- INSTR_COUNT=16, continuous ready: last delivered pc=15. done=1 one cycle after the buffer drains. imem_en stays 0 afterwards.
- While done=1, redirect to pc=2: done=0 next cycle, delivery resumes at pc=2. A second case redirects to pc=20 and done re-asserts.
- reset_n asserted mid-stream with a read in flight: all outputs return to reset values asynchronously. After release, delivery restarts at RESET_PC with no stale instruction.

Source files
------------

// File: rtl/mips16_pkg.sv
// Shared definitions for the 16-bit MIPS datapath: widths, fetch state and opcode field.
package mips16_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 32;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;

    typedef enum logic {
        FETCH,
        HALTED
    } fetch_state_t;

    function automatic logic [OPC_HI-OPC_LO:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry FIFO of {instr, pc} between the instruction memory and decode.
module fetch_skid_buffer #(
    parameter int INSTR_W = 32,
    parameter int ADDR_W  = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               push,
    input  logic [INSTR_W-1:0] push_instr,
    input  logic [ADDR_W-1:0]  push_pc,
    input  logic               pop,
    input  logic               flush,
    output logic [INSTR_W-1:0] head_instr,
    output logic [ADDR_W-1:0]  head_pc,
    output logic [1:0]         count
);

    logic [INSTR_W-1:0] instr_q [2];
    logic [ADDR_W-1:0]  pc_q    [2];
    logic               wr_ptr;
    logic               rd_ptr;

    // Flush only rewinds the pointers; stale entry data is harmless once count is zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                instr_q[wr_ptr] <= push_instr;
                pc_q[wr_ptr]    <= push_pc;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head_instr = instr_q[rd_ptr];
    assign head_pc    = pc_q[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads a 1-cycle synchronous instruction memory and
// feeds decode through a 2-entry buffer, honouring downstream redirects.
module instr_fetch_unit #(
    parameter int ADDR_W      = mips16_pkg::ADDR_W,
    parameter int INSTR_W     = mips16_pkg::INSTR_W,
    parameter int INSTR_COUNT = 16,
    parameter int RESET_PC    = 0
) (
    input  logic               clock,
    input  logic               reset_n,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [ADDR_W-1:0]  out_next_pc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               done
);

    import mips16_pkg::*;

    // One extra bit so that INSTR_COUNT == 2^ADDR_W is never reached by a wrapping PC.
    localparam logic [ADDR_W:0] END_PC = (ADDR_W+1)'(INSTR_COUNT);

    fetch_state_t       state;
    fetch_state_t       next_state;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_inc;
    logic [ADDR_W-1:0]  inflight_pc;
    logic               inflight;
    logic               issue;
    logic               push;
    logic               pop;
    logic               redirect_halts;
    logic [2:0]         occupancy;
    logic [1:0]         count;
    logic [1:0]         next_count;
    logic [INSTR_W-1:0] head_instr;
    logic [ADDR_W-1:0]  head_pc;

    assign out_valid      = (count != 2'd0) & !redirect_valid;
    assign pop            = out_valid & out_ready;
    assign occupancy      = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign issue          = (state == FETCH) & !redirect_valid & (occupancy < 3'd2);
    assign imem_en        = issue & reset_n;
    assign imem_addr      = pc;
    assign push           = inflight & !redirect_valid;
    assign pc_inc         = pc + ADDR_W'(1);
    assign redirect_halts = ({1'b0, redirect_pc} >= END_PC);
    assign next_count     = redirect_valid ? 2'd0 : count + {1'b0, push} - {1'b0, pop};

    assign out_instr   = head_instr;
    assign out_pc      = head_pc;
    assign out_next_pc = (count != 2'd0) ? head_pc + ADDR_W'(1) : '0;

    always_comb begin
        next_state = state;
        if (redirect_valid) begin
            next_state = redirect_halts ? HALTED : FETCH;
        end else if (issue && ({1'b0, pc_inc} == END_PC)) begin
            next_state = HALTED;
        end
    end

    // done is computed from next-cycle values so it tracks a redirect with one cycle of delay.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= FETCH;
            pc          <= ADDR_W'(RESET_PC);
            inflight    <= 1'b0;
            inflight_pc <= '0;
            done        <= 1'b0;
        end else begin
            state    <= next_state;
            inflight <= issue;
            done     <= (next_state == HALTED) & (next_count == 2'd0) & !issue;
            if (issue) begin
                inflight_pc <= pc;
            end
            if (redirect_valid) begin
                pc <= redirect_pc;
            end else if (issue) begin
                pc <= pc_inc;
            end
        end
    end

    fetch_skid_buffer #(
        .INSTR_W(INSTR_W),
        .ADDR_W (ADDR_W)
    ) u_buffer (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .push_instr(imem_data),
        .push_pc   (inflight_pc),
        .pop       (pop),
        .flush     (redirect_valid),
        .head_instr(head_instr),
        .head_pc   (head_pc),
        .count     (count)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized
// ready/redirect traffic compared every cycle against an occupancy-level model.
module tb_instr_fetch_unit;

    import mips16_pkg::*;

    localparam int COUNT    = 16;
    localparam int START_PC = 0;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic               imem_en;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic [ADDR_W-1:0]  out_next_pc;
    logic               redirect_valid = 1'b0;
    logic [ADDR_W-1:0]  redirect_pc = '0;
    logic               done;

    int n_checks = 0;
    int n_fail   = 0;

    int m_issue_pc    = START_PC;
    int m_deliver_pc  = START_PC;
    int m_outstanding = 0;
    bit m_inflight    = 1'b0;
    bit m_done        = 1'b0;

    always #5 clock = ~clock;

    instr_fetch_unit #(
        .ADDR_W     (ADDR_W),
        .INSTR_W    (INSTR_W),
        .INSTR_COUNT(COUNT),
        .RESET_PC   (START_PC)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .imem_en       (imem_en),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .out_next_pc   (out_next_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .done          (done)
    );

    function automatic logic [31:0] mem_word(input int addr);
        return 32'h100 + addr;
    endfunction

    always @(posedge clock) begin
        if (imem_en) imem_data <= mem_word(int'(imem_addr));
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit ready, input bit redir, input int target);
        @(posedge clock);
        #1;
        out_ready      = ready;
        redirect_valid = redir;
        redirect_pc    = ADDR_W'(target);
    endtask

    task automatic waitSample();
        @(negedge clock);
        #1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_imem_en"},     32'(imem_en), 32'd0);
        checkOutput({tag, "_imem_addr"},   32'(imem_addr), 32'(START_PC));
        checkOutput({tag, "_out_valid"},   32'(out_valid), 32'd0);
        checkOutput({tag, "_out_instr"},   out_instr, 32'd0);
        checkOutput({tag, "_out_pc"},      32'(out_pc), 32'd0);
        checkOutput({tag, "_out_next_pc"}, 32'(out_next_pc), 32'd0);
        checkOutput({tag, "_done"},        32'(done), 32'd0);
    endtask

    task automatic checkHead(input string tag, input int pc);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_pc"},    32'(out_pc), 32'(pc));
        checkOutput({tag, "_instr"}, out_instr, mem_word(pc));
        checkOutput({tag, "_next"},  32'(out_next_pc), 32'((pc + 1) % 65536));
    endtask

    // The model tracks outstanding work (issued but not yet handed to decode) and
    // the next pc to issue and to deliver; everything else follows from those.
    always @(negedge clock) begin
        int buffered;
        bit exp_valid;
        bit exp_pop;
        bit exp_issue;
        if (!reset_n) begin
            m_issue_pc    = START_PC;
            m_deliver_pc  = START_PC;
            m_outstanding = 0;
            m_inflight    = 1'b0;
            m_done        = 1'b0;
        end else begin
            buffered  = m_outstanding - int'(m_inflight);
            exp_valid = (buffered > 0) && !redirect_valid;
            exp_pop   = exp_valid && out_ready;
            exp_issue = !redirect_valid && (m_issue_pc < COUNT) && ((m_outstanding - int'(exp_pop)) < 2);

            checkOutput("model_out_valid", 32'(out_valid), 32'(exp_valid));
            checkOutput("model_imem_en",   32'(imem_en), 32'(exp_issue));
            checkOutput("model_done",      32'(done), 32'(m_done));
            if (exp_issue) checkOutput("model_imem_addr", 32'(imem_addr), 32'(m_issue_pc));
            if (exp_valid) begin
                checkOutput("model_out_pc",      32'(out_pc), 32'(m_deliver_pc));
                checkOutput("model_out_instr",   out_instr, mem_word(m_deliver_pc));
                checkOutput("model_out_next_pc", 32'(out_next_pc), 32'((m_deliver_pc + 1) % 65536));
            end

            if (redirect_valid) begin
                m_issue_pc    = int'(redirect_pc);
                m_deliver_pc  = int'(redirect_pc);
                m_outstanding = 0;
                m_inflight    = 1'b0;
            end else begin
                if (exp_pop) begin
                    m_deliver_pc++;
                    m_outstanding--;
                end
                if (exp_issue) begin
                    m_issue_pc++;
                    m_outstanding++;
                end
                m_inflight = exp_issue;
            end
            m_done = (m_issue_pc >= COUNT) && (m_outstanding == 0);
        end
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        checkResetValues("reset");

        // Cycle 0 is the first cycle with reset released.
        @(posedge clock);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        waitSample();
        checkOutput("c0_valid", 32'(out_valid), 32'd0);
        checkOutput("c0_imem_en", 32'(imem_en), 32'd1);
        applyStimulus(1, 0, 0);
        waitSample();
        checkOutput("c1_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0);
            waitSample();
            checkHead("stream", i);
        end

        // Backpressure with pc 3 at the head.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0);
            waitSample();
            checkHead("hold", 3);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0);
            waitSample();
            checkHead("release", 3 + i);
        end

        // Redirect to 4, hold it at the head, then redirect to 9.
        applyStimulus(1, 1, 4);
        waitSample();
        checkOutput("redir4_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 0);
            waitSample();
            checkOutput("redir4_gap", 32'(out_valid), 32'd0);
        end
        applyStimulus(0, 0, 0);
        waitSample();
        checkHead("redir4_head", 4);
        applyStimulus(1, 1, 9);
        waitSample();
        checkOutput("redir9_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 0, 0);
            waitSample();
            checkOutput("redir9_gap", 32'(out_valid), 32'd0);
        end
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1, 0, 0);
            waitSample();
            checkHead("tail", 9 + i);
            checkOutput("tail_done", 32'(done), 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0);
            waitSample();
            checkOutput("end_done", 32'(done), 32'd1);
            checkOutput("end_valid", 32'(out_valid), 32'd0);
            checkOutput("end_imem_en", 32'(imem_en), 32'd0);
        end

        // Restart from done, then redirect past the program end.
        applyStimulus(1, 1, 2);
        waitSample();
        checkOutput("restart_done_same", 32'(done), 32'd1);
        applyStimulus(1, 0, 0);
        waitSample();
        checkOutput("restart_done_next", 32'(done), 32'd0);
        applyStimulus(1, 0, 0);
        waitSample();
        checkOutput("restart_gap", 32'(out_valid), 32'd0);
        applyStimulus(1, 0, 0);
        waitSample();
        checkHead("restart", 2);
        applyStimulus(1, 1, 20);
        waitSample();
        checkOutput("past_end_valid", 32'(out_valid), 32'd0);
        applyStimulus(1, 0, 0);
        waitSample();
        checkOutput("past_end_done", 32'(done), 32'd1);
        checkOutput("past_end_imem_en", 32'(imem_en), 32'd0);

        // Randomized ready/redirect traffic, checked by the model process.
        for (int i = 0; i < 800; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, int'($urandom_range(0, 19)));
        end

        // Reset while a read is in flight.
        applyStimulus(1, 1, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        #1;
        checkOutput("pre_reset_imem_en", 32'(imem_en), 32'd1);
        reset_n = 1'b0;
        #1;
        checkResetValues("async_reset");
        repeat (2) @(posedge clock);
        #1;
        reset_n        = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        waitSample();
        checkOutput("post_reset_c0", 32'(out_valid), 32'd0);
        applyStimulus(1, 0, 0);
        waitSample();
        checkOutput("post_reset_c1", 32'(out_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0);
            waitSample();
            checkHead("post_reset", i);
        end

        applyStimulus(1, 0, 0);
        @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
